// File: rtl/exc_ctrl_if.sv
// rtl/exc_ctrl_if.sv - M-stage/CP0 bus between the pipeline and the exception arbiter
interface exc_ctrl_if;
  logic [5:0]  irq_in;
  logic [31:0] sr;
  logic [31:0] epc_in;
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_bd;
  logic [4:0]  m_exc;
  logic        m_eret;
  logic        cp0_we1;
  logic        cp0_we2;
  logic        cp0_bd;
  logic [4:0]  cp0_ex;
  logic [5:0]  cp0_hwint;
  logic [31:0] cp0_epc;
  logic        flush;
  logic        redirect;
  logic [31:0] pc_target;

  modport slave (
    input  irq_in, sr, epc_in, m_valid, m_pc, m_bd, m_exc, m_eret,
    output cp0_we1, cp0_we2, cp0_bd, cp0_ex, cp0_hwint, cp0_epc,
           flush, redirect, pc_target
  );

  modport master (
    output irq_in, sr, epc_in, m_valid, m_pc, m_bd, m_exc, m_eret,
    input  cp0_we1, cp0_we2, cp0_bd, cp0_ex, cp0_hwint, cp0_epc,
           flush, redirect, pc_target
  );
endinterface

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - exception/interrupt/eret arbitration ahead of CP0
// Optional IRQ_SYNC_EN: 2-flop synchronizer on irq_in.
module exc_ctrl #(
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input logic       clk,
  input logic       reset,
  exc_ctrl_if.slave bus
);

  typedef enum logic {IDLE, GUARD} state_t;

  state_t     state, state_next;
  logic [5:0] irq_s;
  logic       irq_rdy;
  logic       exc_rdy;
  logic       unused_sr_bits;

`ifdef IRQ_SYNC_EN
  logic [5:0] irq_meta;
  logic [5:0] irq_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_meta <= '0;
      irq_sync <= '0;
    end else begin
      irq_meta <= bus.irq_in;
      irq_sync <= irq_meta;
    end
  end

  assign irq_s = irq_sync;
`else
  assign irq_s = bus.irq_in;
`endif

  assign bus.cp0_hwint  = irq_s;
  assign unused_sr_bits = ^{bus.sr[31:16], bus.sr[9:2]};

  assign irq_rdy = (|(irq_s & bus.sr[15:10])) & bus.sr[0] & ~bus.sr[1];
  assign exc_rdy = bus.m_valid & (bus.m_exc != 5'd0) & ~bus.sr[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Interrupt beats exception beats eret; a bubble defers a ready interrupt.
  always_comb begin
    state_next    = state;
    bus.cp0_we1   = 1'b0;
    bus.cp0_we2   = 1'b0;
    bus.cp0_bd    = 1'b0;
    bus.cp0_ex    = 5'd0;
    bus.cp0_epc   = 32'd0;
    bus.flush     = 1'b0;
    bus.redirect  = 1'b0;
    bus.pc_target = 32'd0;
    case (state)
      IDLE: begin
        if (irq_rdy && bus.m_valid) begin
          bus.cp0_we1   = 1'b1;
          bus.cp0_bd    = bus.m_bd;
          bus.cp0_epc   = bus.m_pc;
          bus.flush     = 1'b1;
          bus.redirect  = 1'b1;
          bus.pc_target = HANDLER_PC;
          state_next    = GUARD;
        end else if (exc_rdy) begin
          bus.cp0_we1   = 1'b1;
          bus.cp0_ex    = bus.m_exc;
          bus.cp0_bd    = bus.m_bd;
          bus.cp0_epc   = bus.m_pc;
          bus.flush     = 1'b1;
          bus.redirect  = 1'b1;
          bus.pc_target = HANDLER_PC;
          state_next    = GUARD;
        end else if (bus.m_valid && bus.m_eret) begin
          bus.cp0_we2   = 1'b1;
          bus.flush     = 1'b1;
          bus.redirect  = 1'b1;
          bus.pc_target = bus.epc_in;
          state_next    = GUARD;
        end
      end
      GUARD: begin
        // Pipeline is refilling; CP0 already holds the new SR/EPC.
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - directed and randomized checks of exc_ctrl against a rule-level model
module tb_exc_ctrl;

  localparam logic [31:0] HPC = 32'h0000_4180;
  localparam logic [79:0] HW_MASK = ~(80'h3F << 66);

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic guard_m = 1'b0;

  exc_ctrl_if bus();

  exc_ctrl #(.HANDLER_PC(HPC)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Expected outputs packed as {we1, we2, bd, ex, hwint, epc, flush, redirect, pc_target}.
  function automatic logic [79:0] model(input logic g, input logic [5:0] irq,
                                        input logic [31:0] s, input logic v,
                                        input logic [31:0] pc, input logic bd,
                                        input logic [4:0] ex, input logic er,
                                        input logic [31:0] epc);
    logic        we1 = 1'b0;
    logic        we2 = 1'b0;
    logic [4:0]  code = 5'd0;
    logic [31:0] tgt = 32'd0;
    logic        irq_take;
    irq_take = v && s[0] && !s[1] && ((irq & s[15:10]) != 6'd0);
    if (!g) begin
      if (irq_take) begin
        we1 = 1'b1; tgt = HPC;
      end else if (v && ex != 5'd0 && !s[1]) begin
        we1 = 1'b1; code = ex; tgt = HPC;
      end else if (v && er) begin
        we2 = 1'b1; tgt = epc;
      end
    end
    return {we1, we2, we1 ? bd : 1'b0, code, irq, we1 ? pc : 32'd0,
            we1 | we2, we1 | we2, tgt};
  endfunction

  task automatic step(input string tag, input bit chk_hw);
    logic [79:0] exp_v, obs_v, msk;
    @(negedge clk);
    #1;
    exp_v = model(guard_m, bus.irq_in, bus.sr, bus.m_valid, bus.m_pc, bus.m_bd,
                  bus.m_exc, bus.m_eret, bus.epc_in);
    obs_v = {bus.cp0_we1, bus.cp0_we2, bus.cp0_bd, bus.cp0_ex, bus.cp0_hwint,
             bus.cp0_epc, bus.flush, bus.redirect, bus.pc_target};
    msk = chk_hw ? {80{1'b1}} : HW_MASK;
    checks++;
    assert ((obs_v & msk) === (exp_v & msk)) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs_v & msk, exp_v & msk);
    end
    @(posedge clk);
    guard_m = reset ? 1'b0 : (exp_v[79] | exp_v[78]);
    #1;
  endtask

  // Hold m_valid low long enough for either synchronizer setting to settle.
  task automatic settle(input string tag);
    bus.m_valid = 1'b0;
    step(tag, 1'b0);
    step(tag, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    bus.irq_in = '0; bus.sr = '0; bus.epc_in = '0; bus.m_valid = 1'b0;
    bus.m_pc = '0; bus.m_bd = 1'b0; bus.m_exc = '0; bus.m_eret = 1'b0;
    step("reset_held", 1'b1);
    reset = 1'b0;
    step("after_release", 1'b1);

    bus.sr = 32'h0000_0401; bus.irq_in = 6'b000001;
    settle("timer_sync");
    bus.m_valid = 1'b1; bus.m_pc = 32'h3010;
    step("timer_take", 1'b1);
    step("timer_guard", 1'b1);

    bus.irq_in = '0;
    settle("ovf_sync");
    bus.sr = 32'h0; bus.m_exc = 5'd12; bus.m_pc = 32'h3020; bus.m_bd = 1'b1; bus.m_valid = 1'b1;
    step("ovf_take", 1'b1);
    step("exc_in_guard", 1'b1);
    bus.sr = 32'h2;
    step("ovf_exl_drop", 1'b1);

    bus.sr = 32'h0000_0401; bus.m_exc = '0; bus.m_bd = 1'b0; bus.irq_in = 6'b000001;
    settle("bubble_1_2");
    step("bubble_3", 1'b1);
    bus.m_valid = 1'b1; bus.m_pc = 32'h3040;
    step("bubble_take", 1'b1);
    step("bubble_guard", 1'b1);

    bus.irq_in = '0;
    settle("eret_sync");
    bus.sr = 32'h2; bus.epc_in = 32'h3050; bus.m_eret = 1'b1; bus.m_valid = 1'b1;
    step("eret", 1'b1);
    step("eret_guard", 1'b1);

    bus.sr = 32'h0000_0401; bus.irq_in = 6'b000001;
    settle("prio_sync");
    bus.m_exc = 5'd10; bus.m_valid = 1'b1; bus.m_pc = 32'h3058;
    step("prio_irq_over_exc_eret", 1'b1);
    step("prio_guard", 1'b1);

    bus.m_exc = '0; bus.m_eret = 1'b0; bus.m_pc = 32'h3060;
    step("pre_reset_take", 1'b1);
    reset = 1'b1; guard_m = 1'b0; bus.m_valid = 1'b0;
    step("reset_in_guard", 1'b0);
    bus.sr = 32'h0; bus.m_exc = 5'd12; bus.m_valid = 1'b1;
    step("reset_state_idle", 1'b0);
    reset = 1'b0; bus.sr = 32'h0000_0401; bus.m_exc = '0;
    settle("post_reset_sync");
    bus.m_valid = 1'b1; bus.m_pc = 32'h3070;
    step("post_reset_retake", 1'b1);

    for (int it = 0; it < 400; it++) begin
      if (it % 12 == 0) begin
        bus.irq_in = 6'($urandom);
        settle("rand_sync");
      end
      bus.sr      = {16'h0, 6'($urandom), 8'h0, ($urandom_range(0, 3) == 0), 1'($urandom)};
      bus.m_valid = ($urandom_range(0, 3) != 0);
      bus.m_pc    = $urandom & 32'hFFFF_FFFC;
      bus.m_bd    = 1'($urandom);
      bus.m_exc   = ($urandom_range(0, 1) != 0) ? 5'($urandom) : 5'd0;
      bus.m_eret  = ($urandom_range(0, 4) == 0);
      bus.epc_in  = $urandom;
      step("rand", 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
